// File: rtl/addsub_pkg.sv
// Shared types, constants and elaboration helpers for the serial adder-subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= 2) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// CHUNK-bit ripple-carry slice built from single-bit full adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_slice #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] carry_s;

    assign carry_s[0] = cin;
    assign cout       = carry_s[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder-subtractor: operands stream LSB first through a CHUNK-bit slice,
// with valid/ready handshakes on both sides and carry/overflow/zero flags.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e                 state_r;
    logic [WIDTH-1:0]       a_r;
    logic [WIDTH-1:0]       b_r;
    logic                   carry_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [WIDTH-1:0]       acc_r;
    logic                   a_msb_r;
    logic                   b_msb_r;

    logic [CHUNK-1:0]       slice_sum_s;
    logic                   slice_cout_s;
    logic [WIDTH+CHUNK-1:0] cat_s;
    logic [WIDTH-1:0]       acc_next_s;

    addsub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_r[CHUNK-1:0]),
        .b    (b_r[CHUNK-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // New sum bits enter at the top; this form also covers CHUNK == WIDTH.
    assign cat_s      = {slice_sum_s, acc_r};
    assign acc_next_s = cat_s[WIDTH+CHUNK-1:CHUNK];

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            cnt_r     <= '0;
            acc_r     <= '0;
            a_msb_r   <= 1'b0;
            b_msb_r   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= op_a;
                        b_r      <= (op_sub == OP_SUB) ? ~op_b : op_b;
                        carry_r  <= op_sub;
                        cnt_r    <= '0;
                        acc_r    <= '0;
                        // Sign bits are shifted out during RUN, so keep them for overflow.
                        a_msb_r  <= op_a[WIDTH-1];
                        b_msb_r  <= (op_sub == OP_SUB) ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
                        in_ready <= 1'b0;
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    carry_r <= slice_cout_s;
                    acc_r   <= acc_next_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        result    <= acc_next_s;
                        carry_out <= slice_cout_s;
                        overflow  <= (a_msb_r == b_msb_r) && (acc_next_s[WIDTH-1] != a_msb_r);
                        zero      <= ~|acc_next_s;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: one instance per CHUNK in {1,2,4,8} at WIDTH=8, checked
// against an arithmetic reference model.
module tb_addsub_serial;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      in_valid_v = '0;
    logic [3:0]      in_ready_v;
    logic [3:0][7:0] a_v = '0;
    logic [3:0][7:0] b_v = '0;
    logic [3:0]      sub_v = '0;
    logic [3:0]      out_valid_v;
    logic [3:0]      out_ready_v = '0;
    logic [3:0][7:0] res_v;
    logic [3:0]      cout_v;
    logic [3:0]      ovf_v;
    logic [3:0]      zero_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        addsub_serial #(
            .WIDTH (8),
            .CHUNK (1 << k)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[k]),
            .in_ready  (in_ready_v[k]),
            .op_a      (a_v[k]),
            .op_b      (b_v[k]),
            .op_sub    (sub_v[k]),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready_v[k]),
            .result    (res_v[k]),
            .carry_out (cout_v[k]),
            .overflow  (ovf_v[k]),
            .zero      (zero_v[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                  output logic [7:0] r, output logic c, output logic v,
                                  output logic z);
        int ua, ub, sa, sb, s;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            r = 8'(ua - ub);
            c = (ua >= ub);
            s = sa - sb;
        end else begin
            r = 8'(ua + ub);
            c = ((ua + ub) > 255);
            s = sa + sb;
        end
        v = (s > 127) || (s < -128);
        z = (r == 8'd0);
    endfunction

    task automatic start(input int k, input logic [7:0] a, input logic [7:0] b, input logic sub);
        int cyc = 0;
        while (!in_ready_v[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_before_accept", 32'(in_ready_v[k]), 32'd1);
        a_v[k]        = a;
        b_v[k]        = b;
        sub_v[k]      = sub;
        in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        a_v[k]        = 8'($urandom);
        b_v[k]        = 8'($urandom);
        sub_v[k]      = 1'($urandom);
    endtask

    task automatic finish(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input bit release_out);
        logic [7:0] er;
        logic ec, ev, ez;
        int cyc = 0;
        model(a, b, sub, er, ec, ev, ez);
        while (!out_valid_v[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(8 >> k));
        check("result", 32'(res_v[k]), 32'(er));
        check("carry_out", 32'(cout_v[k]), 32'(ec));
        check("overflow", 32'(ovf_v[k]), 32'(ev));
        check("zero", 32'(zero_v[k]), 32'(ez));
        if (release_out) begin
            out_ready_v[k] = 1'b1;
            @(posedge clk); #1;
            out_ready_v[k] = 1'b0;
            check("out_valid_drop", 32'(out_valid_v[k]), 32'd0);
            check("in_ready_return", 32'(in_ready_v[k]), 32'd1);
        end
    endtask

    task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic sub);
        start(k, a, b, sub);
        finish(k, a, b, sub, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready_v[1]), 32'd1);
        check("rst_out_valid", 32'(out_valid_v[1]), 32'd0);
        check("rst_result", 32'(res_v[1]), 32'd0);
        check("rst_flags", 32'({cout_v[1], ovf_v[1], zero_v[1]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases at CHUNK=2
        op(1, 8'd100, 8'd27, 1'b0);
        op(1, 8'd100, 8'd28, 1'b0);
        op(1, 8'hFF, 8'h01, 1'b0);
        op(1, 8'd5, 8'd7, 1'b1);
        op(1, 8'h80, 8'h01, 1'b1);
        op(1, 8'h55, 8'h55, 1'b1);

        // Backpressure: result held, new operands refused until release
        start(1, 8'd100, 8'd27, 1'b0);
        finish(1, 8'd100, 8'd27, 1'b0, 1'b0);
        a_v[1] = 8'd3;
        b_v[1] = 8'd4;
        sub_v[1] = 1'b0;
        in_valid_v[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready_v[1]), 32'd0);
            check("bp_out_valid", 32'(out_valid_v[1]), 32'd1);
            check("bp_result", 32'(res_v[1]), 32'h7F);
            check("bp_flags", 32'({cout_v[1], ovf_v[1], zero_v[1]}), 32'd0);
        end
        out_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[1] = 1'b0;
        check("bp_release_valid", 32'(out_valid_v[1]), 32'd0);
        check("bp_release_ready", 32'(in_ready_v[1]), 32'd1);
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        check("bp_accept_next", 32'(in_ready_v[1]), 32'd0);
        finish(1, 8'd3, 8'd4, 1'b0, 1'b1);

        // Reset mid-RUN after two chunks
        start(1, 8'd100, 8'd28, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready_v[1]), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid_v[1]), 32'd0);
        check("mid_rst_result", 32'(res_v[1]), 32'd0);
        check("mid_rst_flags", 32'({cout_v[1], ovf_v[1], zero_v[1]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(1, 8'd3, 8'd4, 1'b0);

        // CHUNK sweep: boundaries then random operands
        for (int k = 0; k < 4; k++) begin
            op(k, 8'hFF, 8'h01, 1'b0);
            op(k, 8'h80, 8'h01, 1'b1);
            op(k, 8'h00, 8'h00, 1'b1);
            for (int i = 0; i < 20; i++) begin
                op(k, 8'($urandom), 8'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor; successor of the fixed 8-bit ripple adder.
- Processes operands CHUNK bits per clock, LSB first, through a CHUNK-bit full-adder slice.
- Has a valid/ready handshake on input and output.
- Reports carry, signed overflow and zero flags.
- Sits between the operand register file and the result writeback in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CHUNK, 2, bits processed per cycle. WIDTH % CHUNK must be 0, else elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op_sub valid.
- in_ready  out  1  block can accept operands.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_out  out  1  carry from MSB. For subtract, 1 = no borrow (A >= B unsigned).
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- On reset, from any state:
  - FSM goes to IDLE.
  - in_ready=1; out_valid=0.
  - result=0, carry_out=0, overflow=0, zero=0.
  - Internal A/B/carry/count registers cleared.
  - An operation in flight is discarded, with no output.
- NCHUNK = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - latch A=op_a;
    - latch B'=op_sub ? ~op_b : op_b;
    - carry reg = op_sub;
    - chunk count=0;
    - go to RUN.
  - Operand ports are ignored when not handshaking.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the slice adds A[CHUNK-1:0] + B'[CHUNK-1:0] + carry reg.
  - The CHUNK sum bits shift into the result register from the top.
  - A and B' shift right by CHUNK.
  - The slice carry-out goes to the carry reg; count increments.
  - The signed-overflow inputs must be captured before shifting: MSB of A and MSB of B' at acceptance.
  - When count == NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1; result and flags stable and held.
  - in_ready=0.
  - On out_ready, go to IDLE next cycle; out_valid deasserts.
- Latency:
  - Operands handshaked on edge N give out_valid=1 after edge N+NCHUNK.
  - CHUNK=WIDTH gives 1-cycle RUN.
  - Throughput: one op per NCHUNK+2 cycles with out_ready held high.
- Flags, set on the edge entering DONE:
  - carry_out = final carry reg.
  - overflow = (A_msb == B'_msb) & (result_msb != A_msb).
  - zero = ~|result.
- Outputs hold their last value in IDLE until the next DONE. Only out_valid qualifies them.
- The simultaneous in_valid in DONE is not accepted. The producer must hold it until in_ready.
- Width rule: no result extension; wrap-around is modulo 2^WIDTH.

Decomposition:
- Package addsub_pkg:
  - state enum (IDLE, RUN, DONE);
  - op encoding constants OP_ADD=0, OP_SUB=1;
  - function for NCHUNK;
  - compile-time check of WIDTH % CHUNK.
- Sub-module addsub_slice, parameter CHUNK:
  - combinational ripple of CHUNK full_adder instances;
  - ports a, b, cin, sum, cout.
- addsub_serial contains only the FSM, shift registers and flags.

Test Plan:
All cases use WIDTH=8, CHUNK=2.
- 100+27, op_sub=0 -> result=0x7F, carry_out=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept.
- 100+28 -> result=0x80, overflow=1, carry_out=0; 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0, zero=1.
- 5-7, op_sub=1 -> result=0xFE, carry_out=0, overflow=0; 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
- 0x55-0x55 -> result=0x00, zero=1, carry_out=1, overflow=0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 and new operands -> result/flags stable, in_ready=0, new operands not taken. Then out_ready=1 -> IDLE, and the new op is accepted the next cycle.
- Reset mid-RUN: assert rst_n=0 asynchronously after 2 chunks -> outputs and flags 0, in_ready=1 immediately. After release, 3+4 -> result=0x07, with no residue from the aborted op.
- Sweep CHUNK=1,2,4,8 with random operands against a reference model, with latency = 8/CHUNK.
